// File: rtl/defines_package.sv
// Shared screen geometry, pixel/vertex payload types and FSM encoding for the scanline filler.
package defines_package;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned ADDR_BITS  = 19;
  localparam int unsigned COORD_BITS = 11;
  localparam int unsigned X_BITS     = COORD_BITS - 1;
  localparam int unsigned Y_BITS     = 9;

  typedef struct packed {
    logic signed [COORD_BITS-1:0] x;
    logic signed [COORD_BITS-1:0] y;
  } Point2D;

  typedef struct packed {
    Point2D v0;
    Point2D v1;
    Point2D v2;
  } Triangle2D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  typedef enum logic [2:0] {
    IDLE,
    BBOX,
    SCAN_L,
    SCAN_R,
    FILL,
    NEXT_ROW,
    DONE
  } fill_state_e;

  // Linear pixel address y*SCREEN_W+x.
  function automatic logic [ADDR_BITS-1:0] pixel_addr(input logic [X_BITS-1:0] x,
                                                      input logic [Y_BITS-1:0] y);
    return ADDR_BITS'(y) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(x);
  endfunction

  // Negative coordinates clamp to 0, large ones to hi.
  function automatic logic [X_BITS-1:0] clamp_coord(input logic signed [COORD_BITS-1:0] v,
                                                    input logic [X_BITS-1:0]            hi);
    if (v[COORD_BITS-1]) return '0;
    if (v[X_BITS-1:0] > hi) return hi;
    return v[X_BITS-1:0];
  endfunction

endpackage

// File: rtl/bbox_calc.sv
// Combinational bounding box of a triangle, clamped to the visible screen.
module bbox_calc
  import defines_package::*;
(
  input  Triangle2D          tgl_i,
  output logic [X_BITS-1:0]  xmin_o,
  output logic [X_BITS-1:0]  xmax_o,
  output logic [Y_BITS-1:0]  ymin_o,
  output logic [Y_BITS-1:0]  ymax_o
);

  function automatic logic signed [COORD_BITS-1:0] min3(input logic signed [COORD_BITS-1:0] a,
                                                       input logic signed [COORD_BITS-1:0] b,
                                                       input logic signed [COORD_BITS-1:0] c);
    logic signed [COORD_BITS-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [COORD_BITS-1:0] max3(input logic signed [COORD_BITS-1:0] a,
                                                       input logic signed [COORD_BITS-1:0] b,
                                                       input logic signed [COORD_BITS-1:0] c);
    logic signed [COORD_BITS-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  always_comb begin
    xmin_o = clamp_coord(min3(tgl_i.v0.x, tgl_i.v1.x, tgl_i.v2.x), X_BITS'(SCREEN_W - 1));
    xmax_o = clamp_coord(max3(tgl_i.v0.x, tgl_i.v1.x, tgl_i.v2.x), X_BITS'(SCREEN_W - 1));
    ymin_o = Y_BITS'(clamp_coord(min3(tgl_i.v0.y, tgl_i.v1.y, tgl_i.v2.y), X_BITS'(SCREEN_H - 1)));
    ymax_o = Y_BITS'(clamp_coord(max3(tgl_i.v0.y, tgl_i.v1.y, tgl_i.v2.y), X_BITS'(SCREEN_H - 1)));
  end

endmodule

// File: rtl/scanline_fill.sv
// Fills a wireframe triangle row by row: find leftmost and rightmost outline bits, then write the span.
module scanline_fill
  import defines_package::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  Triangle2D            i_triangle,
  input  Color                 i_color,
  output logic                 wf_ren,
  output logic [ADDR_BITS-1:0] wf_addr,
  input  logic                 wf_rdata,
  output logic                 fb_we,
  output logic [ADDR_BITS-1:0] fb_addr,
  output Color                 fb_wdata,
  output logic                 busy,
  output logic                 done
);

  fill_state_e          state_q, state_d;
  Triangle2D            tgl_q, tgl_d;
  Color                 color_q, color_d, fb_wdata_q, fb_wdata_d;
  logic [X_BITS-1:0]    xmin_q, xmin_d, xmax_q, xmax_d, x_q, x_d;
  logic [X_BITS-1:0]    req_x_q, req_x_d, rd_x_q, rd_x_d, l_q, l_d, r_q, r_d;
  logic [Y_BITS-1:0]    ymax_q, ymax_d, y_q, y_d;
  logic                 issuing_q, issuing_d, rd_vld_q, rd_vld_d;
  logic                 wf_ren_q, wf_ren_d, fb_we_q, fb_we_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_BITS-1:0] wf_addr_q, wf_addr_d, fb_addr_q, fb_addr_d;
  logic [X_BITS-1:0]    bb_xmin, bb_xmax;
  logic [Y_BITS-1:0]    bb_ymin, bb_ymax;

  bbox_calc u_bbox (
    .tgl_i  (tgl_q),
    .xmin_o (bb_xmin),
    .xmax_o (bb_xmax),
    .ymin_o (bb_ymin),
    .ymax_o (bb_ymax)
  );

  // Read requests are tagged with their x; the SRAM answers one cycle after wf_ren.
  always_comb begin
    state_d    = state_q;
    tgl_d      = tgl_q;
    color_d    = color_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymax_d     = ymax_q;
    x_d        = x_q;
    y_d        = y_q;
    l_d        = l_q;
    r_d        = r_q;
    issuing_d  = issuing_q;
    req_x_d    = x_q;
    rd_vld_d   = wf_ren_q;
    rd_x_d     = req_x_q;
    wf_ren_d   = 1'b0;
    wf_addr_d  = wf_addr_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tgl_d   = i_triangle;
          color_d = i_color;
          state_d = BBOX;
        end
      end
      BBOX: begin
        xmin_d    = bb_xmin;
        xmax_d    = bb_xmax;
        ymax_d    = bb_ymax;
        y_d       = bb_ymin;
        x_d       = bb_xmin;
        issuing_d = 1'b1;
        state_d   = SCAN_L;
      end
      SCAN_L: begin
        if (issuing_q) begin
          wf_ren_d  = 1'b1;
          wf_addr_d = pixel_addr(x_q, y_q);
          if (x_q == xmax_q) issuing_d = 1'b0;
          else               x_d       = x_q + 1'b1;
        end
        if (rd_vld_q && wf_rdata) begin
          // Leftmost hit found: drop any reads still in flight.
          l_d       = rd_x_q;
          x_d       = xmax_q;
          issuing_d = 1'b1;
          wf_ren_d  = 1'b0;
          rd_vld_d  = 1'b0;
          state_d   = SCAN_R;
        end else if (!issuing_q && !wf_ren_q) begin
          state_d = NEXT_ROW;
        end
      end
      SCAN_R: begin
        if (issuing_q) begin
          wf_ren_d  = 1'b1;
          wf_addr_d = pixel_addr(x_q, y_q);
          if (x_q == l_q) issuing_d = 1'b0;
          else            x_d       = x_q - 1'b1;
        end
        if (rd_vld_q && wf_rdata) begin
          r_d       = rd_x_q;
          x_d       = l_q;
          issuing_d = 1'b0;
          wf_ren_d  = 1'b0;
          rd_vld_d  = 1'b0;
          state_d   = FILL;
        end else if (!issuing_q && !wf_ren_q) begin
          r_d     = l_q;
          x_d     = l_q;
          state_d = FILL;
        end
      end
      FILL: begin
        fb_we_d    = 1'b1;
        fb_addr_d  = pixel_addr(x_q, y_q);
        fb_wdata_d = color_q;
        if (x_q == r_q) state_d = NEXT_ROW;
        else            x_d     = x_q + 1'b1;
      end
      NEXT_ROW: begin
        if (y_q >= ymax_q) begin
          state_d = DONE;
        end else begin
          y_d       = y_q + 1'b1;
          x_d       = xmin_q;
          issuing_d = 1'b1;
          state_d   = SCAN_L;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      tgl_q      <= '0;
      color_q    <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymax_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      l_q        <= '0;
      r_q        <= '0;
      req_x_q    <= '0;
      rd_x_q     <= '0;
      issuing_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      wf_ren_q   <= 1'b0;
      wf_addr_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgl_q      <= tgl_d;
      color_q    <= color_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymax_q     <= ymax_d;
      x_q        <= x_d;
      y_q        <= y_d;
      l_q        <= l_d;
      r_q        <= r_d;
      req_x_q    <= req_x_d;
      rd_x_q     <= rd_x_d;
      issuing_q  <= issuing_d;
      rd_vld_q   <= rd_vld_d;
      wf_ren_q   <= wf_ren_d;
      wf_addr_q  <= wf_addr_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wf_ren   = wf_ren_q;
  assign wf_addr  = wf_addr_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/scanline_fill.md
SCANLINE_FILL -- requirements
Module: scanline_fill

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-003 SHALL have port start  input  1  single-cycle request to fill the triangle outline already drawn in the wireframe SRAM.
REQ-004 SHALL have port i_triangle  input  Triangle2D  projected triangle; bounds the scan.
REQ-005 SHALL have port i_color  input  Color  fill color.
REQ-006 SHALL have port wf_ren  output  1  wireframe SRAM read strobe.
REQ-007 SHALL have port wf_addr  output  ADDR_BITS  wireframe read address, y*SCREEN_W+x.
REQ-008 SHALL have port wf_rdata  input  1  outline bit; valid the cycle after wf_ren.
REQ-009 SHALL have port fb_we  output  1  framebuffer write strobe.
REQ-010 SHALL have port fb_addr  output  ADDR_BITS  framebuffer address, y*SCREEN_W+x.
REQ-011 SHALL have port fb_wdata  output  Color  pixel color.
REQ-012 SHALL have ports busy  output  1  high outside IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL latch i_triangle and i_color on an accepted start (start high in IDLE); inputs are ignored thereafter.
REQ-014 SHALL ignore start while busy.
REQ-015 SHALL compute the bounding box xmin/xmax/ymin/ymax from the three latched vertices, clamped to 0..SCREEN_W-1 and 0..SCREEN_H-1, in state BBOX (one cycle).
REQ-016 SHALL use states IDLE, BBOX, SCAN_L, SCAN_R, FILL, NEXT_ROW, DONE.
REQ-017 SCAN_L SHALL read x = xmin..xmax, one read per cycle, on row y; the first x whose wf_rdata=1 becomes L; remaining reads in flight are discarded.
REQ-018 If no bit is set on the row, SCAN_L SHALL go to NEXT_ROW without any fb write.
REQ-019 SCAN_R SHALL read x = xmax down to L; the first set bit becomes R (R=L when only one bit is set).
REQ-020 FILL SHALL assert fb_we for exactly R-L+1 consecutive cycles with fb_addr for x = L..R on row y and fb_wdata = latched color.
REQ-021 NEXT_ROW SHALL increment y; y>ymax SHALL go to DONE, otherwise to SCAN_L.
REQ-022 DONE SHALL pulse done for one cycle and return to IDLE; busy SHALL drop in the same cycle as done's deassertion to IDLE.
REQ-023 Degenerate triangle (all vertices equal) SHALL scan exactly one pixel position.
REQ-024 Address arithmetic SHALL be ADDR_BITS wide unsigned; no wrap across rows is permitted (x never exceeds xmax).
REQ-025 wf_ren and fb_we SHALL never be asserted in the same cycle.

Reset
REQ-026 On n_rst low the block SHALL asynchronously enter IDLE with wf_ren=0, fb_we=0, done=0, busy=0, all addresses and fb_wdata 0.
REQ-027 Reset mid-operation SHALL abandon the fill with no further fb writes; the next start SHALL begin a fresh fill.

Structure
REQ-028 SCREEN_W (640), SCREEN_H (480), ADDR_BITS (19), Point2D, Triangle2D and Color SHALL come from defines_package.
REQ-029 A sub-module bbox_calc (combinational min/max of three Point2D with clamping) SHALL be used; the FSM and address counters live in scanline_fill.

Verification
REQ-030 Triangle (2,1),(6,1),(4,3), outline bits at row1 x=2..6, row2 x=3 and 5, row3 x=4 -> writes row1 x2..6, row2 x3..5, row3 x4; 9 fb writes; done once.
REQ-031 Row inside bbox with no outline bits -> zero fb writes for that row; scan continues to next row.
REQ-032 All vertices at (10,10) with bit set -> exactly one fb write at address 10*640+10 with i_color.
REQ-033 start pulsed again while busy, with a different color -> ignored; all writes use the first color.
REQ-034 Vertex at x=700,y=500 -> bbox clamped to 639/479; no address exceeds 307199.
REQ-035 n_rst asserted during FILL -> fb_we=0 immediately, busy=0; a subsequent start completes normally.
